// File: rtl/regfile_multiport.sv
// Multi-port register file: two write ports (memory, ALU) with ALU priority on
// address collisions, NUM_RD registered read ports, optional write bypass, post-reset clear.
module regfile_multiport #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned NUM_RD = 3,
  parameter bit          BYPASS = 1'b1,
  parameter logic [15:0] KEY    = 16'h0032
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_mem,
  input  logic [ADDR_W-1:0]        addr_mem,
  input  logic [DATA_W-1:0]        wdata_mem,
  input  logic                     we_alu,
  input  logic [ADDR_W-1:0]        addr_alu,
  input  logic [DATA_W-1:0]        wdata_alu,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     init_busy,
  output logic                     wr_conflict,
  output logic [15:0]              key_access
);

  localparam int unsigned RD_W = NUM_RD * DATA_W;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_mem_ok, wr_alu_ok;
  logic [RD_W-1:0]     rd_data_d;
  logic                rd_valid_d, init_busy_d, wr_conflict_d;
  logic [ADDR_W-1:0]   rd_sel;
  logic [DATA_W-1:0]   rd_word;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  assign key_access = KEY;
  assign wr_mem_ok  = (state_q == S_READY) && we_mem && in_range(addr_mem);
  assign wr_alu_ok  = (state_q == S_READY) && we_alu && in_range(addr_alu);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: walk the clear counter once over every entry
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_READY;
          clr_cnt_d = '0;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
    endcase
  end

  // Output next-values; registered below
  always_comb begin
    rd_data_d     = '0;
    rd_sel        = '0;
    rd_word       = '0;
    rd_valid_d    = (state_q == S_READY);
    init_busy_d   = (state_d == S_CLEAR);
    wr_conflict_d = wr_mem_ok && wr_alu_ok && (addr_mem == addr_alu);
    if (state_q == S_READY) begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
        rd_sel  = rd_addr[i*ADDR_W +: ADDR_W];
        rd_word = '0;
        if (in_range(rd_sel)) begin
          rd_word = mem[rd_sel];
          if (BYPASS) begin
            // ALU checked last so it wins a same-address collision
            if (wr_mem_ok && (addr_mem == rd_sel)) rd_word = wdata_mem;
            if (wr_alu_ok && (addr_alu == rd_sel)) rd_word = wdata_alu;
          end
        end
        rd_data_d[i*DATA_W +: DATA_W] = rd_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      init_busy   <= 1'b1;
      wr_conflict <= 1'b0;
    end else begin
      rd_data     <= rd_data_d;
      rd_valid    <= rd_valid_d;
      init_busy   <= init_busy_d;
      wr_conflict <= wr_conflict_d;
    end
  end

  // Storage array; the later ALU assignment overrides the memory port on collision
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr_mem_ok) mem[addr_mem] <= wdata_mem;
      if (wr_alu_ok) mem[addr_alu] <= wdata_alu;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: three instances (bypass on/off, DEPTH 16/12) share stimulus
// and are compared every cycle against an array-based reference model.
module tb_regfile_multiport;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 3;
  localparam int unsigned ND = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               we_mem, we_alu;
  logic [AW-1:0]      addr_mem, addr_alu;
  logic [DW-1:0]      wdata_mem, wdata_alu;
  logic [NR*AW-1:0]   rd_addr;

  logic [NR*DW-1:0]   rd_data_o     [ND];
  logic               rd_valid_o    [ND];
  logic               init_busy_o   [ND];
  logic               wr_conflict_o [ND];
  logic [15:0]        key_o         [ND];

  int unsigned        depth_m [ND] = '{16, 16, 12};
  bit                 byp_m   [ND] = '{1'b1, 1'b0, 1'b1};
  logic [DW-1:0]      mem_m   [ND][16];
  int                 clr_left [ND];
  logic [NR*DW-1:0]   exp_data  [ND];
  logic               exp_valid [ND];
  logic               exp_busy  [ND];
  logic               exp_conf  [ND];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .NUM_RD(NR), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst(rst), .we_mem(we_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .we_alu(we_alu), .addr_alu(addr_alu), .wdata_alu(wdata_alu), .rd_addr(rd_addr),
    .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]), .init_busy(init_busy_o[0]),
    .wr_conflict(wr_conflict_o[0]), .key_access(key_o[0]));

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .NUM_RD(NR), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst), .we_mem(we_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .we_alu(we_alu), .addr_alu(addr_alu), .wdata_alu(wdata_alu), .rd_addr(rd_addr),
    .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]), .init_busy(init_busy_o[1]),
    .wr_conflict(wr_conflict_o[1]), .key_access(key_o[1]));

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12), .NUM_RD(NR), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst(rst), .we_mem(we_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .we_alu(we_alu), .addr_alu(addr_alu), .wdata_alu(wdata_alu), .rd_addr(rd_addr),
    .rd_data(rd_data_o[2]), .rd_valid(rd_valid_o[2]), .init_busy(init_busy_o[2]),
    .wr_conflict(wr_conflict_o[2]), .key_access(key_o[2]));

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_reset_exp(input int d);
    clr_left[d]  = int'(depth_m[d]);
    exp_data[d]  = '0;
    exp_valid[d] = 1'b0;
    exp_busy[d]  = 1'b1;
    exp_conf[d]  = 1'b0;
  endtask

  // Reference behaviour for one rising edge, from the current inputs
  task automatic model_edge();
    for (int d = 0; d < int'(ND); d++) begin
      logic [DW-1:0] nm [16];
      int unsigned   a;
      if (rst) begin
        set_reset_exp(d);
      end else if (clr_left[d] > 0) begin
        clr_left[d]--;
        exp_data[d]  = '0;
        exp_valid[d] = 1'b0;
        exp_conf[d]  = 1'b0;
        exp_busy[d]  = (clr_left[d] != 0);
        if (clr_left[d] == 0)
          for (int j = 0; j < 16; j++) mem_m[d][j] = '0;
      end else begin
        nm = mem_m[d];
        if (we_mem && addr_mem < depth_m[d]) nm[addr_mem] = wdata_mem;
        if (we_alu && addr_alu < depth_m[d]) nm[addr_alu] = wdata_alu;
        for (int i = 0; i < int'(NR); i++) begin
          a = rd_addr[i*AW +: AW];
          if (a >= depth_m[d])  exp_data[d][i*DW +: DW] = '0;
          else if (byp_m[d])    exp_data[d][i*DW +: DW] = nm[a];
          else                  exp_data[d][i*DW +: DW] = mem_m[d][a];
        end
        exp_conf[d]  = we_mem && we_alu && (addr_mem == addr_alu) && (addr_mem < depth_m[d]);
        exp_valid[d] = 1'b1;
        exp_busy[d]  = 1'b0;
        mem_m[d]     = nm;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < int'(ND); d++) begin
      chk($sformatf("%s.u%0d.rd_data", tag, d), rd_data_o[d], exp_data[d]);
      chk($sformatf("%s.u%0d.rd_valid", tag, d), 96'(rd_valid_o[d]), 96'(exp_valid[d]));
      chk($sformatf("%s.u%0d.init_busy", tag, d), 96'(init_busy_o[d]), 96'(exp_busy[d]));
      chk($sformatf("%s.u%0d.wr_conflict", tag, d), 96'(wr_conflict_o[d]), 96'(exp_conf[d]));
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    we_mem = 1'b0; we_alu = 1'b0;
    addr_mem = '0; addr_alu = '0;
    wdata_mem = '0; wdata_alu = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  // Assert reset between edges, check the immediate effect, hold one edge, release
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    for (int d = 0; d < int'(ND); d++) set_reset_exp(d);
    #1;
    check_all({tag, ".async"});
    step({tag, ".held"});
    rst = 1'b0;
  endtask

  task automatic count_busy(input string tag, input int unsigned exp_a, input int unsigned exp_c);
    int unsigned na, nc;
    na = init_busy_o[0] ? 1 : 0;
    nc = init_busy_o[2] ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      step(tag);
      if (init_busy_o[0]) na++;
      if (init_busy_o[2]) nc++;
    end
    chk({tag, ".busy_cycles16"}, 96'(na), 96'(exp_a));
    chk({tag, ".busy_cycles12"}, 96'(nc), 96'(exp_c));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_rd(0, 0, 0);
    for (int d = 0; d < int'(ND); d++) begin
      set_reset_exp(d);
      for (int j = 0; j < 16; j++) mem_m[d][j] = '0;
    end
    #1;
    for (int d = 0; d < int'(ND); d++) chk("key_in_reset", 96'(key_o[d]), 96'(16'h0032));
    check_all("reset");
    step("reset_edge");
    rst = 1'b0;

    // Clear sequence length after release
    count_busy("clear", 16, 12);
    for (int k = 0; k < 6; k++) begin
      set_rd(AW'(3*k), AW'((3*k+1) % 16), AW'((3*k+2) % 16));
      step("read_zero");
    end

    // Both ports, distinct addresses
    we_mem = 1'b1; addr_mem = 4'd5; wdata_mem = 32'hDEADBEEF;
    we_alu = 1'b1; addr_alu = 4'd9; wdata_alu = 32'h12345678;
    step("wr_basic");
    chk("basic_no_conflict", 96'(wr_conflict_o[0]), 96'(0));
    idle();
    set_rd(5, 9, 5);
    step("rd_basic");
    chk("basic_read", rd_data_o[0], {32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF});

    // Same-address collision
    we_mem = 1'b1; addr_mem = 4'd3; wdata_mem = 32'h1111_1111;
    we_alu = 1'b1; addr_alu = 4'd3; wdata_alu = 32'h2222_2222;
    set_rd(0, 0, 0);
    step("collide");
    chk("conflict_pulse", 96'(wr_conflict_o[0]), 96'(1));
    idle();
    set_rd(3, 3, 3);
    step("collide_after");
    chk("conflict_drop", 96'(wr_conflict_o[0]), 96'(0));
    chk("collide_alu_wins", rd_data_o[0], {3{32'h2222_2222}});

    // Read-during-write with and without bypass
    we_mem = 1'b1; addr_mem = 4'd7; wdata_mem = 32'hA5A5A5A5;
    set_rd(0, 0, 0);
    step("byp_setup");
    idle();
    we_alu = 1'b1; addr_alu = 4'd7; wdata_alu = 32'h0000_00FF;
    set_rd(7, 7, 7);
    step("byp_rdw");
    chk("bypass_on", rd_data_o[0], {3{32'h0000_00FF}});
    chk("bypass_off", rd_data_o[1], {3{32'hA5A5A5A5}});
    idle();
    step("byp_next");
    chk("bypass_off_next", rd_data_o[1], {3{32'h0000_00FF}});

    // Out-of-range on the 12-entry instance
    we_mem = 1'b1; addr_mem = 4'd11; wdata_mem = 32'hCAFE0011;
    step("oor_setup");
    we_mem = 1'b1; addr_mem = 4'd13; wdata_mem = 32'hFFFFFFFF;
    we_alu = 1'b1; addr_alu = 4'd13; wdata_alu = 32'hFFFFFFFF;
    step("oor_write");
    chk("oor_no_conflict", 96'(wr_conflict_o[2]), 96'(0));
    idle();
    set_rd(13, 11, 13);
    step("oor_read");
    chk("oor_read", rd_data_o[2], {32'h0, 32'hCAFE0011, 32'h0});

    // Reset in the middle of the clear sequence
    set_rd(0, 0, 0);
    pulse_reset("rst1");
    for (int k = 0; k < 8; k++) step("clear_part");
    pulse_reset("rst_mid");
    count_busy("clear_again", 16, 12);

    // Randomised traffic
    for (int k = 0; k < 10000; k++) begin
      we_mem    = 1'($urandom_range(0, 1));
      we_alu    = 1'($urandom_range(0, 1));
      addr_mem  = AW'($urandom_range(0, 15));
      addr_alu  = ($urandom_range(0, 7) == 0) ? addr_mem : AW'($urandom_range(0, 15));
      wdata_mem = $urandom;
      wdata_alu = $urandom;
      rd_addr   = NR*AW'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW +: AW] = addr_alu;
      step("rand");
    end

    for (int d = 0; d < int'(ND); d++) chk("key_end", 96'(key_o[d]), 96'(16'h0032));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
